instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Writer-side counterpart of the core's instruction decoder: accepts symbolic instruction descriptors over a valid/ready stream and encodes them into RV32I machine words.
- Covers lw, sw, R-type (add, sub, slt, or, and, sra) and beq.
- Writes the encoded words sequentially into instruction memory through a stallable write port.
- Used by the test harness and boot loader to build programs for the single-cycle core.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.
- DEPTH, 64, number of 32-bit words the loader may write before reporting full (power of two not required).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new program at BASE_ADDR.
- finish  input  1  one-cycle pulse; ends the current program.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  loader can accept a descriptor.
- in_kind  input  2  00 lw, 01 sw, 10 R-type, 11 beq.
- in_alu  input  3  R-type op, same code as the core ALUControl: 000 add, 001 sub, 101 slt, 011 or, 010 and, 110 sra.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  13  signed immediate; lw/sw use [11:0]; beq uses [12:0] as the byte offset.
- imem_we  output  1  write request to instruction memory.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  encoded instruction.
- imem_ready  input  1  memory accepted the write this cycle.
- count  output  clog2(DEPTH+1)  words written in the current program.
- busy  output  1  high in any state except IDLE and DONE.
- done  output  1  high in DONE.
- err  output  1  sticky illegal-descriptor flag; cleared by start.

Behaviour:
- Reset values: state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr = BASE_ADDR; imem_wdata = 0; count = 0.
- FSM states: IDLE, ACCEPT, WRITE, TERM, DONE.
- IDLE:
  - start -> ACCEPT.
  - addr = BASE_ADDR, count = 0, err = 0.
- ACCEPT:
  - in_ready = 1.
  - Legal handshake (in_valid & in_ready): latch the encoded word into imem_wdata; next state WRITE. Encoded word appears on imem_wdata one cycle after the handshake.
  - Illegal descriptor: set err; no write; stay in ACCEPT. Illegal means R-type with an unlisted in_alu code, or beq with in_imm[0] = 1.
  - finish -> TERM. If finish and in_valid occur in the same cycle, the descriptor is accepted first and finish is ignored.
- WRITE:
  - in_ready = 0; imem_we = 1; imem_addr and imem_wdata held stable until imem_ready.
  - On imem_ready: addr += 4, count += 1.
  - If count becomes DEPTH -> DONE; else -> ACCEPT.
  - A finish pulse arriving in WRITE is latched and applied on the next entry to ACCEPT.
- TERM: resolved by the macro (see Optional Feature). Without the macro, TERM -> DONE in one cycle.
- DONE:
  - done = 1; outputs hold.
  - start -> ACCEPT with a full restart (addr = BASE_ADDR, count = 0, err = 0).
- start while busy: aborts the current program and restarts immediately; any pending write is dropped (imem_we deasserts in the same cycle start is sampled).
- Encoding rules, opcode in [6:0]:
  - lw: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - sw: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - R-type: {f7, rs2, rs1, f3, rd, 7'b0110011}.
    - add: f7 = 0000000, f3 = 000.
    - sub: f7 = 0100000, f3 = 000.
    - slt: f7 = 0000000, f3 = 010.
    - or: f7 = 0000000, f3 = 110.
    - and: f7 = 0000000, f3 = 111.
    - sra: f7 = 0100000, f3 = 101.
  - beq: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}.
- Address arithmetic is 32-bit modulo; no wrap check beyond DEPTH.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous); no partial write is completed.

Optional Feature:
- Macro: INSTR_LOADER_TERM_EN.
- Defined:
  - TERM issues one extra write of the halt word 32'h0000_0063 (beq x0,x0,0 self-loop) at the current address, using the same WRITE handshake, then enters DONE.
  - count includes the halt word.
  - If count == DEPTH on entry to TERM, the halt word is skipped and the loader goes straight to DONE.
- Undefined: TERM -> DONE directly; no halt word is written.

Test Plan:
- start, then add rd=3 rs1=1 rs2=2, imem_ready tied 1 -> one write at 0x0 of 0x002081B3; count = 1.
- Sequence lw rd=5 rs1=2 imm=8; sw rs2=6 rs1=2 imm=12; sub rd=4 rs1=1 rs2=2 -> writes 0x00812283 @0x0, 0x00612623 @0x4, 0x40208233 @0x8.
- beq rs1=1 rs2=2 imm=-8, with imem_ready held low 3 cycles -> imem_we high for 4 cycles with 0xFE208CE3 stable; in_ready = 0 throughout; addr then advances to 0x4.
- R-type with in_alu = 3'b100, then beq with imm = 5 -> no writes; err = 1; count = 0; next legal descriptor is still accepted.
- DEPTH = 2: three add descriptors -> two writes, then done = 1, in_ready = 0; with INSTR_LOADER_TERM_EN and DEPTH = 4, one add then finish -> writes 0x002081B3 @0x0 and 0x00000063 @0x4, count = 2.
- Assert rst_n low during WRITE -> imem_we = 0 and state IDLE immediately; after a new start, addr = BASE_ADDR and count = 0.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Descriptor stream plus instruction-memory write port of the encoder/loader.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the descriptor side, imem_we/imem_ready on the memory side.
//
// Signals:
//   in_valid/in_ready  descriptor handshake
//   in_kind            00 lw, 01 sw, 10 R-type, 11 beq
//   in_alu             R-type ALU code
//   in_rd/rs1/rs2      register fields
//   in_imm             13-bit signed immediate
//   imem_we            write request
//   imem_addr          byte address of the word being written
//   imem_wdata         encoded instruction
//   imem_ready         memory accepted the write
// modport slave is the loader side; modport master is the producer/memory side.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [2:0]  in_alu;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;

    modport slave (
        input  in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output imem_we, imem_addr, imem_wdata,
        input  imem_ready
    );

    modport master (
        output in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  imem_we, imem_addr, imem_wdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic lw/sw/R-type/beq descriptors into RV32I words and writes them to imem.
// Latency: encoded word on imem_wdata one cycle after the descriptor handshake.
// Backpressure: in_ready low while a write is outstanding; imem_we held until imem_ready.
//
// Ports: clk, rst_n (async active-low), start/finish pulses, bus (instr_encoder_loader_if.slave),
//        count (words written this program), busy, done, err (sticky illegal descriptor).
// Optional macro INSTR_LOADER_TERM_EN: on finish, append the halt word 32'h0000_0063.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          finish,
    instr_encoder_loader_if.slave         bus,
    output logic [CW-1:0]                 count,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        TERM   = 3'd3,
        DONE   = 3'd4
    } state_t;

`ifdef INSTR_LOADER_TERM_EN
    localparam logic [31:0] HALT_WORD = 32'h0000_0063;
`endif

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          fin_pend_q, fin_pend_d;   // finish seen during WRITE
    logic          halt_q, halt_d;           // current write is the halt word

    function automatic logic alu_legal(input logic [2:0] alu);
        case (alu)
            3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b110: alu_legal = 1'b1;
            default:                                        alu_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [2:0]  alu,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = 7'b0000000;
        f3 = 3'b000;
        case (alu)
            3'b001:  begin f7 = 7'b0100000; f3 = 3'b000; end
            3'b101:  f3 = 3'b010;
            3'b011:  f3 = 3'b110;
            3'b010:  f3 = 3'b111;
            3'b110:  begin f7 = 7'b0100000; f3 = 3'b101; end
            default: f3 = 3'b000;
        endcase
        case (kind)
            2'b00:   encode = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            2'b01:   encode = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            2'b10:   encode = {f7, rs2, rs1, f3, rd, 7'b0110011};
            default: encode = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        endcase
    endfunction

    logic desc_legal;
    always_comb begin
        desc_legal = 1'b1;
        if (bus.in_kind == 2'b10 && !alu_legal(bus.in_alu)) desc_legal = 1'b0;
        if (bus.in_kind == 2'b11 && bus.in_imm[0])          desc_legal = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_d      = err_q;
        fin_pend_d = fin_pend_q;
        halt_d     = halt_q;

        if (start) begin
            // Restart from any state; an outstanding write is abandoned.
            state_d    = ACCEPT;
            addr_d     = BASE_ADDR;
            count_d    = '0;
            err_d      = 1'b0;
            fin_pend_d = 1'b0;
            halt_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d     = BASE_ADDR;
                    count_d    = '0;
                    err_d      = 1'b0;
                    fin_pend_d = 1'b0;
                    halt_d     = 1'b0;
                end
                ACCEPT: begin
                    if (fin_pend_q) begin
                        // in_ready is held low here so no descriptor is lost.
                        fin_pend_d = 1'b0;
                        state_d    = TERM;
                    end else if (bus.in_valid && desc_legal) begin
                        wdata_d = encode(bus.in_kind, bus.in_alu, bus.in_rd,
                                         bus.in_rs1, bus.in_rs2, bus.in_imm);
                        state_d = WRITE;
                    end else begin
                        if (bus.in_valid) err_d = 1'b1;
                        if (finish)       state_d = TERM;
                    end
                end
                WRITE: begin
                    if (finish) fin_pend_d = 1'b1;
                    if (bus.imem_ready) begin
                        addr_d  = addr_q + 32'd4;
                        count_d = count_q + CW'(1);
                        halt_d  = 1'b0;
                        if (halt_q || count_q == CW'(DEPTH - 1)) begin
                            state_d    = DONE;
                            fin_pend_d = 1'b0;
                        end else begin
                            state_d = ACCEPT;
                        end
                    end
                end
                TERM: begin
`ifdef INSTR_LOADER_TERM_EN
                    if (count_q == CW'(DEPTH)) begin
                        state_d = DONE;
                    end else begin
                        wdata_d = HALT_WORD;
                        halt_d  = 1'b1;
                        state_d = WRITE;
                    end
`else
                    state_d = DONE;
`endif
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'h0;
            count_q    <= '0;
            err_q      <= 1'b0;
            fin_pend_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_q      <= err_d;
            fin_pend_q <= fin_pend_d;
            halt_q     <= halt_d;
        end
    end

    // start gates both handshakes combinationally so an aborted cycle moves nothing.
    assign bus.in_ready   = (state_q == ACCEPT) && !fin_pend_q && !start;
    assign bus.imem_we    = (state_q == WRITE) && !start;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count          = count_q;
    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE);
    assign err            = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] word;
        bit          legal;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

`ifdef INSTR_LOADER_TERM_EN
    localparam int TERM_WORDS = 1;
`else
    localparam int TERM_WORDS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_kind = '0;
    logic [2:0]  in_alu = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [12:0] in_imm = '0;
    logic        imem_ready = 1'b1;

    logic [6:0]  count0;
    logic        busy0, done0, err0;
    logic [1:0]  count1;
    logic        busy1, done1, err1;

    int total = 0;
    int bad = 0;
    int w1_cnt = 0;
    logic [31:0] exp_addr = 32'h0;
    sb_t sb_q[$];
    sb_t pe;

    instr_encoder_loader_if if0();
    instr_encoder_loader_if if1();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_kind  = in_kind;   assign if1.in_kind  = in_kind;
    assign if0.in_alu   = in_alu;    assign if1.in_alu   = in_alu;
    assign if0.in_rd    = in_rd;     assign if1.in_rd    = in_rd;
    assign if0.in_rs1   = in_rs1;    assign if1.in_rs1   = in_rs1;
    assign if0.in_rs2   = in_rs2;    assign if1.in_rs2   = in_rs2;
    assign if0.in_imm   = in_imm;    assign if1.in_imm   = in_imm;
    assign if0.imem_ready = imem_ready;
    assign if1.imem_ready = imem_ready;

    instr_encoder_loader dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .bus(if0.slave),
        .count(count0), .busy(busy0), .done(done0), .err(err0)
    );

    instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .bus(if1.slave),
        .count(count1), .busy(busy1), .done(done1), .err(err1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write-port monitor: every accepted write pops the scoreboard.
    always @(negedge clk) begin
        if (if0.imem_we && imem_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write addr=%h data=%h required=none",
                         if0.imem_addr, if0.imem_wdata);
            end else begin
                pe = sb_q.pop_front();
                chk("wr_addr", if0.imem_addr, pe.addr);
                chk("wr_data", if0.imem_wdata, pe.data);
            end
        end
        if (if1.imem_we && imem_ready) w1_cnt++;
    end

    task automatic push(input logic [31:0] w);
        sb_q.push_back('{exp_addr, w});
        exp_addr += 32'd4;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 32'h0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_kind = v.kind; in_alu = v.alu; in_rd = v.rd;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        @(negedge clk);
        while (!if0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!if0.in_ready) begin
            bad++;
            $display("FAIL handshake_timeout in_ready=0 required=1");
        end else if (v.legal) begin
            push(v.word);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done0, 1'b1);
        @(posedge clk); #1;
    endtask

    vec_t vt[16];
    vec_t v_add;
    vec_t v_bad_alu;
    vec_t v_bad_beq;
    vec_t v_beq_m8;
    bit   err_exp;
    int   legal_n;

    initial begin
        v_add     = '{2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0,     32'h002081B3, 1'b1};
        v_bad_alu = '{2'b10, 3'b100, 5'd3, 5'd1, 5'd2, 13'd0,     32'h0,        1'b0};
        v_bad_beq = '{2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'd5,     32'h0,        1'b0};
        v_beq_m8  = '{2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FF8,  32'hFE208CE3, 1'b1};

        vt[0]  = v_add;
        vt[1]  = '{2'b00, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8,    32'h00812283, 1'b1};
        vt[2]  = '{2'b01, 3'b000, 5'd0, 5'd2, 5'd6, 13'd12,   32'h00612623, 1'b1};
        vt[3]  = '{2'b10, 3'b001, 5'd4, 5'd1, 5'd2, 13'd0,    32'h40208233, 1'b1};
        vt[4]  = v_bad_alu;
        vt[5]  = v_beq_m8;
        vt[6]  = v_bad_beq;
        vt[7]  = '{2'b10, 3'b101, 5'd3, 5'd1, 5'd2, 13'd0,    32'h0020A1B3, 1'b1};
        vt[8]  = '{2'b10, 3'b011, 5'd3, 5'd1, 5'd2, 13'd0,    32'h0020E1B3, 1'b1};
        vt[9]  = '{2'b10, 3'b010, 5'd3, 5'd1, 5'd2, 13'd0,    32'h0020F1B3, 1'b1};
        vt[10] = '{2'b10, 3'b110, 5'd3, 5'd1, 5'd2, 13'd0,    32'h4020D1B3, 1'b1};
        vt[11] = '{2'b00, 3'b000, 5'd1, 5'd0, 5'd0, 13'h1FFC, 32'hFFC02083, 1'b1};
        vt[12] = '{2'b01, 3'b000, 5'd0, 5'd3, 5'd5, 13'h1FFC, 32'hFE51AE23, 1'b1};
        vt[13] = '{2'b11, 3'b000, 5'd0, 5'd3, 5'd4, 13'd16,   32'h00418863, 1'b1};
        vt[14] = '{2'b10, 3'b111, 5'd3, 5'd1, 5'd2, 13'd0,    32'h0,        1'b0};
        vt[15] = '{2'b00, 3'b000, 5'd5, 5'd2, 5'd0, 13'h1008, 32'h00812283, 1'b1};

        // Reset state
        #12;
        chk("rst_in_ready", if0.in_ready, 1'b0);
        chk("rst_we", if0.imem_we, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_err", err0, 1'b0);
        chk("rst_addr", if0.imem_addr, 32'h0);
        chk("rst_wdata", if0.imem_wdata, 32'h0);
        chk("rst_count", count0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table: encodings and illegal descriptors in one program
        pulse_start();
        @(negedge clk);
        chk("start_busy", busy0, 1'b1);
        chk("start_in_ready", if0.in_ready, 1'b1);
        @(posedge clk); #1;
        err_exp = 1'b0;
        legal_n = 0;
        for (int i = 0; i < 16; i++) begin
            send(vt[i]);
            if (vt[i].legal) begin
                drain();
                legal_n++;
            end else begin
                err_exp = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_err", i), err0, err_exp);
            chk($sformatf("vec%0d_count", i), count0, legal_n);
            @(posedge clk); #1;
        end

        // Illegal descriptors alone: no write, err set, then a legal one is accepted
        pulse_start();
        @(negedge clk);
        chk("restart_err_clr", err0, 1'b0);
        @(posedge clk); #1;
        send(v_bad_alu);
        send(v_bad_beq);
        @(negedge clk);
        chk("illegal_err", err0, 1'b1);
        chk("illegal_count", count0, 32'd0);
        chk("illegal_addr", if0.imem_addr, 32'h0);
        @(posedge clk); #1;
        send(v_add);
        drain();
        @(negedge clk);
        chk("after_illegal_count", count0, 32'd1);
        @(posedge clk); #1;

        // Write stall: beq -8 held for 3 not-ready cycles
        pulse_start();
        imem_ready = 1'b0;
        send(v_beq_m8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_we", c), if0.imem_we, 1'b1);
            chk($sformatf("stall%0d_wdata", c), if0.imem_wdata, 32'hFE208CE3);
            chk($sformatf("stall%0d_addr", c), if0.imem_addr, 32'h0);
            chk($sformatf("stall%0d_in_ready", c), if0.in_ready, 1'b0);
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        chk("stall3_we", if0.imem_we, 1'b1);
        chk("stall3_in_ready", if0.in_ready, 1'b0);
        @(posedge clk); #1;
        drain();
        @(negedge clk);
        chk("stall_addr_next", if0.imem_addr, 32'h4);
        chk("stall_count", count0, 32'd1);
        chk("stall_we_off", if0.imem_we, 1'b0);
        @(posedge clk); #1;

        // DEPTH=2 instance fills after two writes
        pulse_start();
        w1_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send(v_add);
            drain();
        end
        @(negedge clk);
        chk("d2_writes", w1_cnt, 32'd2);
        chk("d2_done", done1, 1'b1);
        chk("d2_in_ready", if1.in_ready, 1'b0);
        chk("d2_count", count1, 32'd2);
        chk("d2_busy", busy1, 1'b0);
        chk("d64_count", count0, 32'd3);
        @(posedge clk); #1;

        // finish from ACCEPT
        pulse_start();
        send(v_add);
        drain();
        pulse_finish();
        if (TERM_WORDS == 1) push(32'h0000_0063);
        wait_done();
        drain();
        @(negedge clk);
        chk("fin_count", count0, 1 + TERM_WORDS);
        chk("fin_busy", busy0, 1'b0);
        chk("fin_in_ready", if0.in_ready, 1'b0);
        @(posedge clk); #1;

        // restart from DONE
        pulse_start();
        @(negedge clk);
        chk("redo_done", done0, 1'b0);
        chk("redo_count", count0, 32'd0);
        chk("redo_addr", if0.imem_addr, 32'h0);
        @(posedge clk); #1;

        // finish arriving during WRITE is deferred
        imem_ready = 1'b0;
        send(v_add);
        pulse_finish();
        imem_ready = 1'b1;
        if (TERM_WORDS == 1) push(32'h0000_0063);
        wait_done();
        drain();
        @(negedge clk);
        chk("latched_fin_count", count0, 1 + TERM_WORDS);
        @(posedge clk); #1;

        // start while a write is pending aborts it
        pulse_start();
        imem_ready = 1'b0;
        send(v_add);
        start = 1'b1;
        #1;
        chk("abort_we", if0.imem_we, 1'b0);
        sb_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 32'h0;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("abort_count", count0, 32'd0);
        chk("abort_addr", if0.imem_addr, 32'h0);
        chk("abort_in_ready", if0.in_ready, 1'b1);
        @(posedge clk); #1;
        send(v_add);
        drain();

        // Asynchronous reset during WRITE
        pulse_start();
        imem_ready = 1'b0;
        send(v_add);
        @(negedge clk);
        chk("prerst_we", if0.imem_we, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", if0.imem_we, 1'b0);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_done", done0, 1'b0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        chk("postrst_addr", if0.imem_addr, 32'h0);
        chk("postrst_count", count0, 32'd0);
        @(posedge clk); #1;
        send(v_add);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
